// File: rtl/lieat_ifu_bht.sv
// lieat_ifu_bht: branch history table, 1-cycle prediction register and redirect latch for the IFU.
// Ports:
//   i_clk, i_rst_n            clock; asynchronous active-low reset
//   i_lkp_*                   lookup request: valid, pc, predecoded imm, is-branch flag, stall
//   o_prdt_*                  registered prediction: valid, taken, index used, next pc
//   i_upd_*                   resolved branch update: enable, index, outcome
//   i_flush_req, i_flush_pc   mispredict flush and the correct next pc
//   o_redir_valid, o_redir_pc pending redirect toward the IFU; i_redir_ready accepts it
//   o_flush_cnt               saturating count of flush cycles
module lieat_ifu_bht #(
    parameter int         XLEN    = 32,
    parameter int         IDX_W   = 5,
    parameter logic [1:0] CNT_RST = 2'b01
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_lkp_valid,
    input  logic [XLEN-1:0]  i_lkp_pc,
    input  logic [XLEN-1:0]  i_lkp_imm,
    input  logic             i_lkp_is_bxx,
    input  logic             i_lkp_stall,
    output logic             o_prdt_valid,
    output logic             o_prdt_taken,
    output logic [IDX_W-1:0] o_prdt_index,
    output logic [XLEN-1:0]  o_prdt_pc,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_index,
    input  logic             i_upd_taken,
    input  logic             i_flush_req,
    input  logic [XLEN-1:0]  i_flush_pc,
    output logic             o_redir_valid,
    output logic [XLEN-1:0]  o_redir_pc,
    input  logic             i_redir_ready,
    output logic [31:0]      o_flush_cnt
);
    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       r_cnt [ENTRIES];
    logic [1:0]       w_upd_cur;
    logic [1:0]       w_upd_cnt;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_c;
    logic             w_taken;
    logic [XLEN-1:0]  w_pc_n;

    assign w_upd_cur = r_cnt[i_upd_index];
    assign w_upd_cnt = i_upd_taken ? (w_upd_cur == 2'b11 ? 2'b11 : w_upd_cur + 2'd1)
                                   : (w_upd_cur == 2'b00 ? 2'b00 : w_upd_cur - 2'd1);

    // Write-first bypass: a lookup of the entry being updated sees the new count.
    assign w_idx   = i_lkp_pc[IDX_W+1:2];
    assign w_c     = (i_upd_en && i_upd_index == w_idx) ? w_upd_cnt : r_cnt[w_idx];
    assign w_taken = i_lkp_is_bxx & w_c[1];
    assign w_pc_n  = w_taken ? i_lkp_pc + i_lkp_imm : i_lkp_pc + XLEN'(4);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_RST;
        end else if (i_upd_en) begin
            r_cnt[i_upd_index] <= w_upd_cnt;
        end
    end

    // Flush kills the in-flight prediction but leaves its payload fields alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_prdt_valid <= 1'b0;
            o_prdt_taken <= 1'b0;
            o_prdt_index <= '0;
            o_prdt_pc    <= '0;
        end else if (i_flush_req) begin
            o_prdt_valid <= 1'b0;
        end else if (!i_lkp_stall) begin
            o_prdt_valid <= i_lkp_valid;
            if (i_lkp_valid) begin
                o_prdt_taken <= w_taken;
                o_prdt_index <= w_idx;
                o_prdt_pc    <= w_pc_n;
            end
        end
    end

    // Newest flush wins, even over a same-cycle handshake of the older redirect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_redir_valid <= 1'b0;
            o_redir_pc    <= '0;
        end else if (i_flush_req) begin
            o_redir_valid <= 1'b1;
            o_redir_pc    <= i_flush_pc;
        end else if (o_redir_valid && i_redir_ready) begin
            o_redir_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_flush_cnt <= '0;
        else if (i_flush_req && o_flush_cnt != 32'hFFFF_FFFF) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
endmodule

// File: tb/tb_lieat_ifu_bht.sv
// tb_lieat_ifu_bht: directed and randomized checks of lieat_ifu_bht against a behavioural model.
module tb_lieat_ifu_bht;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lkp_valid, lkp_is_bxx, lkp_stall, upd_en, upd_taken, flush_req, redir_ready;
    logic [31:0] lkp_pc, lkp_imm, flush_pc;
    logic [4:0]  upd_index;
    logic        prdt_valid, prdt_taken, redir_valid;
    logic [4:0]  prdt_index;
    logic [31:0] prdt_pc, redir_pc, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model: counters as plain integers 0..3, outputs as plain variables.
    int          m_cnt [32];
    logic        m_pv, m_pt, m_rv;
    logic [4:0]  m_pi;
    logic [31:0] m_ppc, m_rpc, m_fc;

    lieat_ifu_bht dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_lkp_valid(lkp_valid), .i_lkp_pc(lkp_pc), .i_lkp_imm(lkp_imm),
        .i_lkp_is_bxx(lkp_is_bxx), .i_lkp_stall(lkp_stall),
        .o_prdt_valid(prdt_valid), .o_prdt_taken(prdt_taken),
        .o_prdt_index(prdt_index), .o_prdt_pc(prdt_pc),
        .i_upd_en(upd_en), .i_upd_index(upd_index), .i_upd_taken(upd_taken),
        .i_flush_req(flush_req), .i_flush_pc(flush_pc),
        .o_redir_valid(redir_valid), .o_redir_pc(redir_pc),
        .i_redir_ready(redir_ready), .o_flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        lkp_valid = 0; lkp_pc = 0; lkp_imm = 0; lkp_is_bxx = 0; lkp_stall = 0;
        upd_en = 0; upd_index = 0; upd_taken = 0;
        flush_req = 0; flush_pc = 0; redir_ready = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 1;
        m_pv = 0; m_pt = 0; m_pi = 0; m_ppc = 0; m_rv = 0; m_rpc = 0; m_fc = 0;
    endtask

    // Advance the model by one clock from the currently driven inputs, then let the DUT clock.
    task automatic cycle();
        int idx, c, nu;
        idx = int'(lkp_pc[6:2]);
        c = m_cnt[idx];
        nu = m_cnt[upd_index];
        if (upd_en) begin
            nu = upd_taken ? ((nu + 1 > 3) ? 3 : nu + 1) : ((nu - 1 < 0) ? 0 : nu - 1);
            if (int'(upd_index) == idx) c = nu;
        end
        if (flush_req) m_pv = 0;
        else if (!lkp_stall) begin
            m_pv = lkp_valid;
            if (lkp_valid) begin
                m_pt = lkp_is_bxx && (c >= 2);
                m_pi = idx[4:0];
                m_ppc = m_pt ? lkp_pc + lkp_imm : lkp_pc + 32'd4;
            end
        end
        if (flush_req) begin m_rv = 1; m_rpc = flush_pc; end
        else if (m_rv && redir_ready) m_rv = 0;
        if (flush_req && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        if (upd_en) m_cnt[upd_index] = nu;
        @(posedge clk); #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] imm, input logic bxx);
        idle(); lkp_valid = 1; lkp_pc = pc; lkp_imm = imm; lkp_is_bxx = bxx;
        cycle(); idle();
    endtask

    task automatic update(input logic [4:0] idx, input logic tk);
        idle(); upd_en = 1; upd_index = idx; upd_taken = tk;
        cycle(); idle();
    endtask

    task automatic test_reset();
        idle(); rst_n = 0; model_reset();
        #1;
        checks++; if (prdt_valid !== 1'b0) begin errors++; $display("FAIL reset_pv got %b exp 0", prdt_valid); end
        checks++; if ({prdt_taken, prdt_index, prdt_pc} !== 38'd0) begin errors++; $display("FAIL reset_prdt got %h exp 0", {prdt_taken, prdt_index, prdt_pc}); end
        checks++; if ({redir_valid, redir_pc} !== 33'd0) begin errors++; $display("FAIL reset_redir got %h exp 0", {redir_valid, redir_pc}); end
        checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_fcnt got %h exp 0", flush_cnt); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_basic();
        lookup(32'h8000_0010, 32'h40, 1);
        checks++; if ({prdt_valid, prdt_taken, prdt_index, prdt_pc} !== {1'b1, 1'b0, 5'd4, 32'h8000_0014})
            begin errors++; $display("FAIL basic_nt got v%b t%b i%0d pc%h exp v1 t0 i4 pc80000014", prdt_valid, prdt_taken, prdt_index, prdt_pc); end
        update(4, 1); update(4, 1);
        lookup(32'h8000_0010, 32'h40, 1);
        checks++; if ({prdt_taken, prdt_pc} !== {1'b1, 32'h8000_0050})
            begin errors++; $display("FAIL basic_tk got t%b pc%h exp t1 pc80000050", prdt_taken, prdt_pc); end
        update(4, 1); update(4, 1); update(4, 1); update(4, 0);
        lookup(32'h8000_0010, 32'h40, 1);
        checks++; if (prdt_taken !== 1'b1) begin errors++; $display("FAIL basic_sat got %b exp 1", prdt_taken); end
        lookup(32'h8000_0010, 32'h40, 0);
        checks++; if ({prdt_taken, prdt_pc} !== {1'b0, 32'h8000_0014})
            begin errors++; $display("FAIL basic_nobxx got t%b pc%h exp t0 pc80000014", prdt_taken, prdt_pc); end
    endtask

    task automatic test_bypass();
        update(4, 0);
        idle(); lkp_valid = 1; lkp_pc = 32'h10; lkp_imm = 32'h40; lkp_is_bxx = 1;
        upd_en = 1; upd_index = 4; upd_taken = 1;
        cycle(); idle();
        checks++; if ({prdt_taken, prdt_pc} !== {1'b1, 32'h50})
            begin errors++; $display("FAIL bypass got t%b pc%h exp t1 pc00000050", prdt_taken, prdt_pc); end
        lookup(32'h10, 32'h40, 1);
        checks++; if (prdt_taken !== 1'b1) begin errors++; $display("FAIL bypass_after got %b exp 1", prdt_taken); end
        update(4, 0);
        lookup(32'h10, 32'h40, 1);
        checks++; if (prdt_taken !== 1'b0) begin errors++; $display("FAIL bypass_cnt2 got %b exp 0", prdt_taken); end
    endtask

    task automatic test_redirect();
        idle(); flush_req = 1; flush_pc = 32'h100; cycle(); idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if ({redir_valid, redir_pc} !== {1'b1, 32'h100})
                begin errors++; $display("FAIL redir_hold got v%b pc%h exp v1 pc00000100", redir_valid, redir_pc); end
        end
        idle(); flush_req = 1; flush_pc = 32'h200; cycle(); idle();
        checks++; if ({redir_valid, redir_pc} !== {1'b1, 32'h200})
            begin errors++; $display("FAIL redir_new got v%b pc%h exp v1 pc00000200", redir_valid, redir_pc); end
        redir_ready = 1; cycle(); idle();
        checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL redir_accept got %b exp 0", redir_valid); end
        checks++; if (flush_cnt !== 32'd2) begin errors++; $display("FAIL redir_fcnt got %0d exp 2", flush_cnt); end
    endtask

    task automatic test_flush_handshake();
        idle(); flush_req = 1; flush_pc = 32'h300; cycle(); idle();
        flush_req = 1; flush_pc = 32'h340; redir_ready = 1;
        lkp_valid = 1; lkp_pc = 32'h60; lkp_is_bxx = 1;
        cycle(); idle();
        checks++; if ({redir_valid, redir_pc} !== {1'b1, 32'h340})
            begin errors++; $display("FAIL fhs_redir got v%b pc%h exp v1 pc00000340", redir_valid, redir_pc); end
        checks++; if (prdt_valid !== 1'b0) begin errors++; $display("FAIL fhs_pv got %b exp 0", prdt_valid); end
        checks++; if (flush_cnt !== 32'd4) begin errors++; $display("FAIL fhs_fcnt got %0d exp 4", flush_cnt); end
        redir_ready = 1; cycle(); idle();
        checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL fhs_clear got %b exp 0", redir_valid); end
    endtask

    task automatic test_stall();
        lookup(32'h20, 32'h80, 0);
        for (int i = 0; i < 2; i++) begin
            idle(); lkp_stall = 1; lkp_valid = 1; lkp_pc = 32'h40; lkp_imm = 32'h8; lkp_is_bxx = 1;
            cycle();
            checks++; if ({prdt_valid, prdt_taken, prdt_index, prdt_pc} !== {1'b1, 1'b0, 5'd8, 32'h24})
                begin errors++; $display("FAIL stall_hold got v%b t%b i%0d pc%h exp v1 t0 i8 pc00000024", prdt_valid, prdt_taken, prdt_index, prdt_pc); end
        end
        idle(); cycle();
        checks++; if (prdt_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", prdt_valid); end
    endtask

    task automatic test_reset_mid();
        update(9, 1); update(9, 1);
        idle(); flush_req = 1; flush_pc = 32'h500; lkp_valid = 1; lkp_pc = 32'h24; cycle(); idle();
        lookup(32'h24, 32'h10, 1);
        checks++; if ({prdt_valid, prdt_taken, redir_valid} !== 3'b111)
            begin errors++; $display("FAIL rmid_pre got %b exp 111", {prdt_valid, prdt_taken, redir_valid}); end
        rst_n = 0; model_reset();
        #1;
        checks++; if ({redir_valid, redir_pc, prdt_valid, flush_cnt} !== 66'd0)
            begin errors++; $display("FAIL rmid_async got %h exp 0", {redir_valid, redir_pc, prdt_valid, flush_cnt}); end
        #3 rst_n = 1;
        lookup(32'h24, 32'h10, 1);
        checks++; if ({prdt_valid, prdt_taken, prdt_index, prdt_pc} !== {1'b1, 1'b0, 5'd9, 32'h28})
            begin errors++; $display("FAIL rmid_cnt got v%b t%b i%0d pc%h exp v1 t0 i9 pc00000028", prdt_valid, prdt_taken, prdt_index, prdt_pc); end
        update(9, 1);
        lookup(32'h24, 32'h10, 1);
        checks++; if (prdt_taken !== 1'b1) begin errors++; $display("FAIL rmid_inc got %b exp 1", prdt_taken); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            lkp_valid   = 1'($urandom_range(0, 3) != 0);
            lkp_pc      = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15)) << 2;
            lkp_imm     = $urandom;
            lkp_is_bxx  = 1'($urandom_range(0, 3) != 0);
            lkp_stall   = 1'($urandom_range(0, 4) == 0);
            upd_en      = 1'($urandom_range(0, 1));
            upd_index   = $urandom_range(0, 1) ? lkp_pc[6:2] : 5'($urandom_range(0, 31));
            upd_taken   = 1'($urandom_range(0, 2) != 0);
            flush_req   = 1'($urandom_range(0, 7) == 0);
            flush_pc    = $urandom;
            redir_ready = 1'($urandom_range(0, 1));
            cycle();
            checks++;
            if ({prdt_valid, prdt_taken, prdt_index, prdt_pc, redir_valid, redir_pc, flush_cnt} !==
                {m_pv, m_pt, m_pi, m_ppc, m_rv, m_rpc, m_fc}) begin
                errors++;
                $display("FAIL rand_outs n=%0d got v%b t%b i%0d pc%h rv%b rpc%h fc%0d exp v%b t%b i%0d pc%h rv%b rpc%h fc%0d",
                    n, prdt_valid, prdt_taken, prdt_index, prdt_pc, redir_valid, redir_pc, flush_cnt,
                    m_pv, m_pt, m_pi, m_ppc, m_rv, m_rpc, m_fc);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_redirect();
        test_flush_handshake();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
